// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// occupancy count, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags that are cleared with clr_err.
//
// Internal state is a pair of (ADDR_WIDTH+1)-bit binary pointers and a
// registered occupancy count. All status flags are decoded from that
// registered count, so wr_en/rd_en never reach a flag combinationally.
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ZERO_C   = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH + 1)'(1);

    // Reject threshold settings that would make the flags meaningless.
    if ((AEMPTY_THRESH < 1) || (AEMPTY_THRESH >= AFULL_THRESH) || (AFULL_THRESH > DEPTH)) begin : g_param_check
        $error("sync_fifo_flags: thresholds must satisfy 1 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr_r;
    logic [ADDR_WIDTH:0]   rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   wr_ptr_nxt_s;
    logic [ADDR_WIDTH:0]   rd_ptr_nxt_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  overflow_r;
    logic                  underflow_r;

    assign full_s       = (count_r == DEPTH_C);
    assign empty_s      = (count_r == ZERO_C);
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_r >= AFULL_C);
    assign almost_empty = (count_r <= AEMPTY_C);
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    // A request is only honoured when the pre-edge flags allow it; this also
    // resolves simultaneous requests on an empty or full FIFO.
    assign wr_acc_s = wr_en & ~full_s;
    assign rd_acc_s = rd_en & ~empty_s;

    // Next pointer values; both wrap naturally modulo 2*DEPTH.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (wr_acc_s) begin
            wr_ptr_nxt_s = wr_ptr_r + ONE_C;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + ONE_C;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

    // Pointer and occupancy registers; count is the pointer distance after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= ZERO_C;
            rd_ptr_r <= ZERO_C;
            count_r  <= ZERO_C;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= wr_ptr_nxt_s - rd_ptr_nxt_s;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Sticky error flags; a new error in the same cycle wins over clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_en && full_s) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (rd_en && empty_s) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; it is valid whenever data is held.
        assign rd_data  = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
        assign rd_valid = ~empty_s;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_r;
        logic                  rd_valid_r;

        // Registered read: one-cycle latency, rd_valid pulses per accepted read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_r  <= '0;
                rd_valid_r <= 1'b0;
            end else begin
                rd_valid_r <= rd_acc_s;
                if (rd_acc_s) begin
                    rd_data_r <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
                end
            end
        end

        assign rd_data  = rd_data_r;
        assign rd_valid = rd_valid_r;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-mode and a FWFT-mode instance share
// the same stimulus and are both checked against a queue-based model.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] wr_data;

    logic       s_full, s_afull, s_empty, s_aempty, s_rd_valid, s_ovf, s_unf;
    logic [7:0] s_rd_data;
    logic [4:0] s_count;
    logic       f_full, f_afull, f_empty, f_aempty, f_rd_valid, f_ovf, f_unf;
    logic [7:0] f_rd_data;
    logic [4:0] f_count;

    always #5 clk = ~clk;

    sync_fifo_flags #(.FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(s_full), .almost_full(s_afull), .rd_en(rd_en), .rd_data(s_rd_data),
        .rd_valid(s_rd_valid), .empty(s_empty), .almost_empty(s_aempty),
        .count(s_count), .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
    );

    sync_fifo_flags #(.FWFT(1)) dut_fw (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_full), .almost_full(f_afull), .rd_en(rd_en), .rd_data(f_rd_data),
        .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_aempty),
        .count(f_count), .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
    );

    // Reference model: the FIFO is a queue of up to 16 words.
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_unf;
    bit         m_rv;
    logic [7:0] m_rd;
    int         n_checks = 0;
    int         n_fail   = 0;

    localparam logic [10:0] RESET_STATUS = 11'b00110000000;

    function automatic logic [10:0] exp_status();
        int n = mq.size();
        return {n == 16, n >= 14, n == 0, n <= 2, 5'(n), m_ovf, m_unf};
    endfunction

    function automatic logic [10:0] std_status();
        return {s_full, s_afull, s_empty, s_aempty, s_count, s_ovf, s_unf};
    endfunction

    function automatic logic [10:0] fw_status();
        return {f_full, f_afull, f_empty, f_aempty, f_count, f_ovf, f_unf};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rv  = 1'b0;
        m_rd  = 8'h00;
    endtask

    // Drive one clock of requests and advance the model by the same edge.
    task automatic cycle(input bit w, input bit r, input logic [7:0] d, input bit c);
        bit was_full;
        bit was_empty;
        wr_en = w; rd_en = r; wr_data = d; clr_err = c;
        @(posedge clk);
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        m_rv = 1'b0;
        if (r && !was_empty) begin
            m_rd = mq.pop_front();
            m_rv = 1'b1;
        end
        if (w && !was_full) mq.push_back(d);
        if (w && was_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r && was_empty) m_unf = 1'b1; else if (c) m_unf = 1'b0;
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
        model_reset();
        #22;
        n_checks++;
        if (std_status() !== RESET_STATUS) begin n_fail++; $display("FAIL reset_std_status: got %b expected %b", std_status(), RESET_STATUS); end
        n_checks++;
        if (fw_status() !== RESET_STATUS) begin n_fail++; $display("FAIL reset_fw_status: got %b expected %b", fw_status(), RESET_STATUS); end
        n_checks++;
        if ({s_rd_valid, s_rd_data, f_rd_valid} !== 10'b0) begin n_fail++; $display("FAIL reset_rd: got %b %h %b expected 0 00 0", s_rd_valid, s_rd_data, f_rd_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b0);
            n_checks++;
            if (std_status() !== exp_status() || fw_status() !== exp_status()) begin n_fail++; $display("FAIL fill_status[%0d]: got %b/%b expected %b", i, std_status(), fw_status(), exp_status()); end
            n_checks++;
            if (s_afull !== (i >= 13) || s_empty !== 1'b0) begin n_fail++; $display("FAIL fill_flags[%0d]: got afull=%b empty=%b expected afull=%b empty=0", i, s_afull, s_empty, (i >= 13)); end
        end
        n_checks++;
        if (f_rd_data !== 8'h00 || s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL fill_head: got fw=%h std_valid=%b expected 00 0", f_rd_data, s_rd_valid); end
        cycle(1'b1, 1'b0, 8'hFF, 1'b0);
        n_checks++;
        if (s_count !== 5'd16 || s_ovf !== 1'b1 || s_full !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got count=%0d ovf=%b full=%b expected 16 1 1", s_count, s_ovf, s_full); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0);
            n_checks++;
            if (s_rd_valid !== 1'b1 || s_rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %b %h expected 1 %h", i, s_rd_valid, s_rd_data, 8'(i)); end
            n_checks++;
            if (std_status() !== exp_status() || s_aempty !== ((15 - i) <= 2)) begin n_fail++; $display("FAIL drain_status[%0d]: got %b expected %b", i, std_status(), exp_status()); end
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (s_rd_valid !== 1'b0 || s_rd_data !== 8'h0F) begin n_fail++; $display("FAIL drain_hold: got %b %h expected 0 0f", s_rd_valid, s_rd_data); end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++;
        if (s_unf !== 1'b1 || s_rd_valid !== 1'b0 || f_rd_valid !== 1'b0 || s_empty !== 1'b1) begin n_fail++; $display("FAIL drain_underflow: got unf=%b valid=%b fvalid=%b empty=%b expected 1 0 0 1", s_unf, s_rd_valid, f_rd_valid, s_empty); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_checks++;
        if (std_status() !== RESET_STATUS) begin n_fail++; $display("FAIL drain_clear: got %b expected %b", std_status(), RESET_STATUS); end
    endtask

    task automatic test_fwft();
        cycle(1'b1, 1'b0, 8'hA5, 1'b0);
        cycle(1'b1, 1'b0, 8'h5A, 1'b0);
        n_checks++;
        if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hA5 || s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_present: got %b %h std_valid=%b expected 1 a5 0", f_rd_valid, f_rd_data, s_rd_valid); end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++;
        if (f_rd_valid !== 1'b1 || f_rd_data !== 8'h5A || s_rd_data !== 8'hA5) begin n_fail++; $display("FAIL fwft_pop1: got %b %h std=%h expected 1 5a a5", f_rd_valid, f_rd_data, s_rd_data); end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++;
        if (f_rd_valid !== 1'b0 || s_rd_data !== 8'h5A || f_empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop2: got valid=%b std=%h empty=%b expected 0 5a 1", f_rd_valid, s_rd_data, f_empty); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 8'h20 + 8'(i), 1'b0);
            exp_d = (i < 5) ? 8'h10 + 8'(i) : 8'h20 + 8'(i - 5);
            n_checks++;
            if (s_rd_valid !== 1'b1 || s_rd_data !== exp_d) begin n_fail++; $display("FAIL b2b_data[%0d]: got %b %h expected 1 %h", i, s_rd_valid, s_rd_data, exp_d); end
            n_checks++;
            if (s_count !== 5'd5 || f_count !== 5'd5 || s_ovf !== 1'b0 || s_unf !== 1'b0 || f_rd_data !== mq[0]) begin n_fail++; $display("FAIL b2b_state[%0d]: got count=%0d ovf=%b unf=%b fw=%h expected 5 0 0 %h", i, s_count, s_ovf, s_unf, f_rd_data, mq[0]); end
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++;
        if (s_rd_data !== 8'h20 + 8'd39 || std_status() !== RESET_STATUS) begin n_fail++; $display("FAIL b2b_drain: got %h %b expected 47 %b", s_rd_data, std_status(), RESET_STATUS); end
    endtask

    task automatic test_simultaneous();
        cycle(1'b1, 1'b1, 8'h33, 1'b0);
        n_checks++;
        if (s_count !== 5'd1 || s_unf !== 1'b1 || s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got count=%0d unf=%b valid=%b expected 1 1 0", s_count, s_unf, s_rd_valid); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        n_checks++;
        if (s_unf !== 1'b0 || f_unf !== 1'b0 || s_count !== 5'd1) begin n_fail++; $display("FAIL simul_clear: got unf=%b/%b count=%0d expected 0 1", s_unf, f_unf, s_count); end
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0);
        cycle(1'b1, 1'b1, 8'hDD, 1'b0);
        n_checks++;
        if (s_count !== 5'd15 || s_ovf !== 1'b1 || s_rd_data !== 8'h33) begin n_fail++; $display("FAIL simul_full: got count=%0d ovf=%b rd=%h expected 15 1 33", s_count, s_ovf, s_rd_data); end
        cycle(1'b1, 1'b0, 8'h6F, 1'b0);
        cycle(1'b1, 1'b0, 8'hEE, 1'b1);
        n_checks++;
        if (s_ovf !== 1'b1 || f_ovf !== 1'b1 || s_count !== 5'd16) begin n_fail++; $display("FAIL simul_clr_vs_ovf: got ovf=%b/%b count=%0d expected 1 16", s_ovf, f_ovf, s_count); end
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'hEE, 1'b0);
        n_checks++;
        if (std_status() !== exp_status()) begin n_fail++; $display("FAIL simul_status: got %b expected %b", std_status(), exp_status()); end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (std_status() !== RESET_STATUS || fw_status() !== RESET_STATUS || s_rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset_full: got %b/%b valid=%b expected %b", std_status(), fw_status(), s_rd_valid, RESET_STATUS); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (s_count !== 5'd0 || s_empty !== 1'b1 || s_ovf !== 1'b0 || s_unf !== 1'b0 || f_rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset_mid: got count=%0d empty=%b ovf=%b unf=%b fvalid=%b expected 0 1 0 0 0", s_count, s_empty, s_ovf, s_unf, f_rd_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'h99, 1'b0);
        n_checks++;
        if (f_rd_data !== 8'h99 || s_count !== 5'd1) begin n_fail++; $display("FAIL areset_fw_first: got %h count=%0d expected 99 1", f_rd_data, s_count); end
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        n_checks++;
        if (s_rd_valid !== 1'b1 || s_rd_data !== 8'h99 || s_empty !== 1'b1) begin n_fail++; $display("FAIL areset_first_read: got %b %h empty=%b expected 1 99 1", s_rd_valid, s_rd_data, s_empty); end
    endtask

    task automatic test_random();
        int wr_pct;
        int rd_pct;
        for (int i = 0; i < 600; i++) begin
            wr_pct = ((i / 100) % 2 == 0) ? 75 : 25;
            rd_pct = 100 - wr_pct;
            cycle($urandom_range(0, 99) < wr_pct, $urandom_range(0, 99) < rd_pct,
                  8'($urandom), $urandom_range(0, 15) == 0);
            n_checks++;
            if (std_status() !== exp_status() || fw_status() !== exp_status()) begin n_fail++; $display("FAIL rand_status[%0d]: got %b/%b expected %b", i, std_status(), fw_status(), exp_status()); end
            n_checks++;
            if (s_rd_valid !== m_rv || s_rd_data !== m_rd) begin n_fail++; $display("FAIL rand_std_read[%0d]: got %b %h expected %b %h", i, s_rd_valid, s_rd_data, m_rv, m_rd); end
            n_checks++;
            if (f_rd_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rand_fw_valid[%0d]: got %b expected %b", i, f_rd_valid, (mq.size() > 0)); end
            if (mq.size() > 0) begin
                n_checks++;
                if (f_rd_data !== mq[0]) begin n_fail++; $display("FAIL rand_fw_data[%0d]: got %h expected %h", i, f_rd_data, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_fwft();
        test_back_to_back();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO; the next-generation buffer for same-domain datapaths where the CDC machinery of the dual-clock FIFO is unnecessary.
- Adds:
  - selectable standard / first-word-fall-through read mode
  - occupancy count
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags with clear
- Sits between a producer and a consumer in one clock domain, e.g. a bench stage feeding a timing-critical pipeline.

Parameters:
- DATA_WIDTH, 8: width of each stored word.
- ADDR_WIDTH, 4: log2 of depth. DEPTH = 1 << ADDR_WIDTH.
- FWFT, 0: read mode. 0 = standard registered read; 1 = first-word fall-through.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2: almost_empty asserts when count <= AEMPTY_THRESH.

Ports:
- clk  input  1  single clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  write word.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AFULL_THRESH.
- rd_en  input  1  read request (standard mode) / pop acknowledge (FWFT).
- rd_data  output  DATA_WIDTH  read word.
- rd_valid  output  1  rd_data is valid (see Behaviour).
- empty  output  1  count == 0.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.
- clr_err  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (async assert, posedge clk release):
  - write pointer = 0, read pointer = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - overflow = 0, underflow = 0, rd_valid = 0, rd_data = 0
  - Memory contents are not reset.
  - Reset mid-operation discards all data immediately.
- Pointers:
  - ADDR_WIDTH+1-bit binary; the low ADDR_WIDTH bits address memory.
  - Each pointer wraps naturally modulo 2*DEPTH.
- Flags are decoded combinationally from the registered count only. No combinational path from wr_en or rd_en to any flag.
- Write accept: wr_en && !full, sampled at the edge.
  - The word is stored at the write pointer and the write pointer increments.
  - wr_en && full: word dropped, pointer unchanged, overflow <= 1.
- Read accept: rd_en && !empty, sampled at the edge. The read pointer increments.
  - rd_en && empty: pointer unchanged, underflow <= 1.
  - In standard mode, rd_valid = 0 for that cycle and rd_data holds.
- Standard mode (FWFT=0):
  - A read accepted at edge N: rd_data = head word and rd_valid = 1 during cycle N+1, i.e. 1-cycle latency.
  - rd_valid is a 1-cycle pulse per accepted read.
  - rd_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - rd_data = mem[read pointer] combinationally; rd_valid = !empty.
  - rd_en pops the presented word; the next word appears the cycle after the pop edge.
  - rd_data while empty is don't-care.
- Count update:
  - +1 on write-only accept, -1 on read-only accept.
  - Unchanged when both or neither are accepted.
- Simultaneous wr_en && rd_en (flags evaluated before the edge):
  - empty: write accepted, read is an underflow. count becomes 1.
  - full: read accepted, write is an overflow. count becomes DEPTH-1.
  - otherwise: both accepted, count unchanged.
- Write-to-read latency: a write at edge N deasserts empty in cycle N+1. That word is readable by rd_en at edge N+1.
- Error flags:
  - overflow and underflow remain set until clr_err.
  - clr_err has priority below a same-cycle new error event: the flag stays 1.
- Elaboration constraints: 1 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH. Violation stops elaboration with $error.

Test Plan:
- Reset then write 16 words 0x00..0x0F (defaults) -> count = 16, full = 1, almost_full asserts after the 14th write, empty deasserts the cycle after the first write. A 17th write leaves count = 16 and sets overflow = 1.
- From full, issue 16 reads, FWFT=0 -> rd_data = 0x00..0x0F, each one cycle after its rd_en with a rd_valid pulse. Then empty = 1 and almost_empty = 1 once count <= 2. A 17th read sets underflow = 1 with rd_valid = 0.
- FWFT=1: write 0xA5 then 0x5A -> rd_data = 0xA5 with rd_valid = 1 before any rd_en; after one pop, rd_data = 0x5A; after the second pop, rd_valid = 0.
- With count = 5, assert wr_en and rd_en together for 40 cycles with incrementing data -> count stays 5, no error flags, read order matches write order across pointer wrap.
- Simultaneous wr_en/rd_en while empty -> count = 1, underflow = 1. Next cycle clr_err alone clears underflow. clr_err with a same-cycle overflow attempt while full -> overflow stays 1.
- Write 7 words, assert rst_n = 0 asynchronously mid-cycle -> count = 0, empty = 1, overflow = underflow = 0 immediately. After release, the first read returns the first word written post-reset.
